plab4_net_echo_terminal: RTL and testbench



---
 rtl/plab4_net_echo_terminal.sv | 126 ++++++++++++
 tb/tb_plab4_net_echo_terminal.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_echo_terminal.sv
// Echo terminal for one ring-network port: accepts ejected messages addressed to this
// node, swaps src/dest and re-injects them through a 2-entry reply FIFO.
// Define PLAB4_NET_ECHO_TERMINAL_INCR_EN to return payload+1 instead of a plain echo.
module plab4_net_echo_terminal #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_node_id       = 0,
  localparam int msg_nbits = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [msg_nbits-1:0] recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [msg_nbits-1:0] send_msg,
  output logic [15:0]          rx_count,
  output logic [15:0]          tx_count,
  output logic [15:0]          drop_count
);

  localparam int p_nb = p_payload_nbits;
  localparam int o_nb = p_opaque_nbits;
  localparam int s_nb = p_srcdest_nbits;
  localparam logic [s_nb-1:0] node_id = s_nb'(p_node_id);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_next;

  logic [msg_nbits-1:0] entry [2];
  logic                 head;
  logic                 wr_ptr;

  logic [s_nb-1:0] dest_in;
  logic [s_nb-1:0] src_in;
  logic [o_nb-1:0] opaque_in;
  logic [p_nb-1:0] payload_in;
  logic [p_nb-1:0] payload_out;
  logic [msg_nbits-1:0] reply;

  logic recv_fire;
  logic send_fire;
  logic dest_match;
  logic enq;
  logic deq;

  assign dest_in    = recv_msg[msg_nbits-1 -: s_nb];
  assign src_in     = recv_msg[msg_nbits-1-s_nb -: s_nb];
  assign opaque_in  = recv_msg[p_nb +: o_nb];
  assign payload_in = recv_msg[p_nb-1:0];

`ifdef PLAB4_NET_ECHO_TERMINAL_INCR_EN
  assign payload_out = payload_in + p_nb'(1);
`else
  assign payload_out = payload_in;
`endif

  assign reply = {src_in, node_id, opaque_in, payload_out};

  assign recv_fire  = recv_val && recv_rdy;
  assign send_fire  = send_val && send_rdy;
  assign dest_match = (dest_in == node_id);
  assign enq        = recv_fire && dest_match;
  assign deq        = send_fire;

  // With one entry held, the free slot is the one opposite the head.
  assign wr_ptr = (state == ONE) ? ~head : head;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next-state logic for FIFO occupancy.
  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      EMPTY: if (enq) state_next = ONE;
      ONE: begin
        if (enq && !deq)      state_next = FULL;
        else if (!enq && deq) state_next = EMPTY;
      end
      FULL:  if (deq) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Output logic: handshake readiness depends on occupancy only.
  always_comb begin
    recv_rdy = (state != FULL);
    send_val = (state != EMPTY);
  end

  // Storage is cleared on reset because send_msg must read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this small buffer is reset explicitly; large RAM arrays normally are not.
      for (int i = 0; i < 2; i++) entry[i] <= '0;
      head <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the write and the head update on the same edge.
      if (enq) entry[wr_ptr] <= reply;
      if (deq) head <= ~head;
    end
  end

  assign send_msg = entry[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (enq)                     rx_count   <= rx_count + 16'd1;
      if (recv_fire && !dest_match) drop_count <= drop_count + 16'd1;
      if (send_fire)               tx_count   <= tx_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_plab4_net_echo_terminal.sv
// Self-checking bench for plab4_net_echo_terminal (node 2, 32/3/3 field widths),
// using a queue-based reference model of the reply buffer and counters.
module tb_plab4_net_echo_terminal;

  localparam int W    = 41;
  localparam int NODE = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         recv_val = 1'b0;
  logic         recv_rdy;
  logic [W-1:0] recv_msg = '0;
  logic         send_val;
  logic         send_rdy = 1'b0;
  logic [W-1:0] send_msg;
  logic [15:0]  rx_count, tx_count, drop_count;

  plab4_net_echo_terminal #(
    .p_payload_nbits(32),
    .p_opaque_nbits (3),
    .p_srcdest_nbits(3),
    .p_node_id      (NODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .recv_msg  (recv_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_msg  (send_msg),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending replies in arrival order, plus traffic counters.
  logic [W-1:0] mq[$];
  logic [15:0]  m_rx, m_tx, m_drop;

  function automatic logic [W-1:0] mk(input logic [2:0] d, input logic [2:0] s,
                                      input logic [2:0] op, input logic [31:0] pay);
    return {d, s, op, pay};
  endfunction

  function automatic logic [W-1:0] reply_of(input logic [W-1:0] m);
    logic [31:0] pay;
    pay = m[31:0];
`ifdef PLAB4_NET_ECHO_TERMINAL_INCR_EN
    pay = pay + 32'd1;
`endif
    return {m[37:35], 3'(NODE), m[34:32], pay};
  endfunction

  function automatic logic [W-1:0] rand_msg(input logic [2:0] d);
    return mk(d, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom);
  endfunction

  // Drives one cycle of inputs, advances the model, and lands 1 time unit after the edge.
  task automatic cycle(input logic rv, input logic [W-1:0] msg, input logic sr,
                       output logic acc, output logic sent);
    recv_val = rv;
    recv_msg = msg;
    send_rdy = sr;
    acc  = rv && (mq.size() < 2);
    sent = sr && (mq.size() != 0);
    if (sent) begin
      void'(mq.pop_front());
      m_tx = m_tx + 16'd1;
    end
    if (acc) begin
      if (msg[40:38] == 3'(NODE)) begin
        mq.push_back(reply_of(msg));
        m_rx = m_rx + 16'd1;
      end else begin
        m_drop = m_drop + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    m_rx = '0; m_tx = '0; m_drop = '0;
  endtask

  task automatic test_reset();
    logic a, s;
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    compared++; if (recv_rdy !== 1'b1) begin mismatched++; $display("FAIL reset_recv_rdy got=%b exp=1", recv_rdy); end
    compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL reset_send_val got=%b exp=0", send_val); end
    compared++; if (send_msg !== '0) begin mismatched++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
    compared++; if ({rx_count, tx_count, drop_count} !== 48'd0) begin mismatched++;
      $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", rx_count, tx_count, drop_count); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, rand_msg(3'(NODE)), 1'b1, a, s);
      compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL reset_idle_send_val cyc=%0d got=%b exp=0", i, send_val); end
    end
  endtask

  task automatic test_single_echo();
    logic a, s;
    logic [W-1:0] exp;
`ifdef PLAB4_NET_ECHO_TERMINAL_INCR_EN
    exp = mk(3'd5, 3'd2, 3'd3, 32'h11);
`else
    exp = mk(3'd5, 3'd2, 3'd3, 32'h10);
`endif
    cycle(1'b1, mk(3'd2, 3'd5, 3'd3, 32'h10), 1'b1, a, s);
    compared++; if (send_val !== 1'b1) begin mismatched++; $display("FAIL echo_send_val got=%b exp=1", send_val); end
    compared++; if (send_msg !== exp) begin mismatched++; $display("FAIL echo_send_msg got=%h exp=%h", send_msg, exp); end
    compared++; if (rx_count !== 16'd1) begin mismatched++; $display("FAIL echo_rx_count got=%0d exp=1", rx_count); end
    cycle(1'b0, '0, 1'b1, a, s);
    compared++; if (tx_count !== 16'd1) begin mismatched++; $display("FAIL echo_tx_count got=%0d exp=1", tx_count); end
    compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL echo_drain_send_val got=%b exp=0", send_val); end
  endtask

  task automatic test_misroute();
    logic a, s;
    logic [15:0] rx_before;
    rx_before = m_rx;
    cycle(1'b1, mk(3'd4, 3'd1, 3'd6, 32'hDEAD_BEEF), 1'b1, a, s);
    compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL misroute_send_val got=%b exp=0", send_val); end
    compared++; if (drop_count !== 16'd1) begin mismatched++; $display("FAIL misroute_drop_count got=%0d exp=1", drop_count); end
    compared++; if (rx_count !== rx_before) begin mismatched++; $display("FAIL misroute_rx_count got=%0d exp=%0d", rx_count, rx_before); end
  endtask

  task automatic test_backpressure();
    logic a, s;
    logic [W-1:0] ma, mb, mc;
    logic [15:0] tx_before;
    tx_before = m_tx;
    ma = rand_msg(3'(NODE)); mb = rand_msg(3'(NODE)); mc = rand_msg(3'(NODE));
    cycle(1'b1, ma, 1'b0, a, s);
    cycle(1'b1, mb, 1'b0, a, s);
    compared++; if (recv_rdy !== 1'b0) begin mismatched++; $display("FAIL bp_full_recv_rdy got=%b exp=0", recv_rdy); end
    cycle(1'b1, mc, 1'b0, a, s);
    compared++; if (recv_rdy !== 1'b0) begin mismatched++; $display("FAIL bp_hold_recv_rdy got=%b exp=0", recv_rdy); end
    compared++; if (send_msg !== reply_of(ma)) begin mismatched++; $display("FAIL bp_stable_msg got=%h exp=%h", send_msg, reply_of(ma)); end
    // Dequeue from FULL; C stays blocked this cycle and recv_rdy rises afterwards.
    cycle(1'b1, mc, 1'b1, a, s);
    compared++; if (recv_rdy !== 1'b1) begin mismatched++; $display("FAIL bp_after_deq_recv_rdy got=%b exp=1", recv_rdy); end
    compared++; if (send_msg !== reply_of(mb)) begin mismatched++; $display("FAIL bp_order_b got=%h exp=%h", send_msg, reply_of(mb)); end
    cycle(1'b1, mc, 1'b1, a, s);
    compared++; if (send_msg !== reply_of(mc)) begin mismatched++; $display("FAIL bp_order_c got=%h exp=%h", send_msg, reply_of(mc)); end
    cycle(1'b0, '0, 1'b1, a, s);
    compared++; if (tx_count !== tx_before + 16'd3) begin mismatched++; $display("FAIL bp_tx_count got=%0d exp=%0d", tx_count, tx_before + 16'd3); end
    compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL bp_drained got=%b exp=0", send_val); end
  endtask

  task automatic test_streaming();
    logic a, s;
    logic [W-1:0] m;
    for (int i = 0; i < 20; i++) begin
      m = (i == 7) ? mk(3'(NODE), 3'd6, 3'd1, 32'hFFFF_FFFF) : rand_msg(3'(NODE));
      cycle(1'b1, m, 1'b1, a, s);
      compared++; if (send_val !== 1'b1 || send_msg !== reply_of(m)) begin mismatched++;
        $display("FAIL stream_reply idx=%0d got=%b/%h exp=1/%h", i, send_val, send_msg, reply_of(m)); end
      compared++; if (recv_rdy !== 1'b1) begin mismatched++; $display("FAIL stream_not_full idx=%0d got=%b exp=1", i, recv_rdy); end
    end
    cycle(1'b0, '0, 1'b1, a, s);
    compared++; if (rx_count !== m_rx || tx_count !== m_tx) begin mismatched++;
      $display("FAIL stream_counts got=%0d/%0d exp=%0d/%0d", rx_count, tx_count, m_rx, m_tx); end
  endtask

  task automatic test_random(input int n);
    logic a, s;
    logic [W-1:0] m;
    for (int i = 0; i < n; i++) begin
      m = rand_msg(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(NODE));
      cycle(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 2) != 0), a, s);
      compared++; if (recv_rdy !== (mq.size() < 2)) begin mismatched++; $display("FAIL rand_recv_rdy cyc=%0d got=%b", i, recv_rdy); end
      compared++; if (send_val !== (mq.size() != 0)) begin mismatched++; $display("FAIL rand_send_val cyc=%0d got=%b", i, send_val); end
      if (mq.size() != 0) begin
        compared++; if (send_msg !== mq[0]) begin mismatched++; $display("FAIL rand_send_msg cyc=%0d got=%h exp=%h", i, send_msg, mq[0]); end
      end
      compared++; if ({rx_count, tx_count, drop_count} !== {m_rx, m_tx, m_drop}) begin mismatched++;
        $display("FAIL rand_counters cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, rx_count, tx_count, drop_count, m_rx, m_tx, m_drop); end
    end
  endtask

  task automatic test_reset_mid();
    logic a, s;
    while (mq.size() < 2) cycle(1'b1, rand_msg(3'(NODE)), 1'b0, a, s);
    compared++; if (recv_rdy !== 1'b0) begin mismatched++; $display("FAIL rmid_full got=%b exp=0", recv_rdy); end
    recv_val = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    compared++; if (send_val !== 1'b0) begin mismatched++; $display("FAIL rmid_send_val got=%b exp=0", send_val); end
    compared++; if (recv_rdy !== 1'b1) begin mismatched++; $display("FAIL rmid_recv_rdy got=%b exp=1", recv_rdy); end
    compared++; if ({rx_count, tx_count, drop_count} !== 48'd0) begin mismatched++;
      $display("FAIL rmid_counters got=%0d/%0d/%0d exp=0/0/0", rx_count, tx_count, drop_count); end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, a, s);
      compared++; if (send_val !== 1'b0 || tx_count !== 16'd0) begin mismatched++;
        $display("FAIL rmid_stale cyc=%0d got=%b/%0d exp=0/0", i, send_val, tx_count); end
    end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_misroute();
    test_backpressure();
    test_streaming();
    test_random(300);
    test_reset_mid();
    test_random(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
